wght_fetch_ctrl: RTL and testbench

Read-side initiator for the weight BRAM (1-cycle registered read, `ren`/`raddr` in, `rdat` out).
- On a start command it walks a contiguous, wrap-around address range and issues reads.
- It tracks the BRAM read latency and buffers returned weights in a small FIFO.
- It presents weights to the neuron datapath as a valid/ready stream, with a last marker and a done pulse.
- Sits between the layer sequencer (command side) and the LIF accumulate unit (stream side), one instance per weight BRAM.

---
 rtl/snn_mem_pkg.sv | 26 ++
 rtl/wght_fifo.sv | 62 ++++++
 rtl/wght_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_wght_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_mem_pkg
//  Description : Shared types and helpers for SNN weight-memory access blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_mem_pkg;

    // Fetch controller states, encoding fixed explicitly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Cycles between a BRAM read enable and its data appearing on rdat.
    localparam int BRAM_RD_LAT = 1;

    // Fold an address that may have stepped one past the end back into range.
    function automatic int unsigned addr_wrap(input int unsigned addr,
                                              input int unsigned depth);
        return (addr >= depth) ? (addr - depth) : addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wght_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wght_fifo
//  Description : Small synchronous shortreal FIFO; push and pop may coincide.
//                Head reads as 0.0 while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module wght_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  shortreal         push_data,
    input  logic             pop,
    output shortreal         pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    shortreal           r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = empty ? 0.0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/wght_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wght_fetch_ctrl
//  Description : Weight BRAM read initiator. Walks a wrap-around address range,
//                issues credit-limited reads and streams the returned weights
//                out as valid/ready with last marker and done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module wght_fetch_ctrl
    import snn_mem_pkg::*;
#(
    parameter int RAM_DEPTH      = 32,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int LEN_WIDTH      = RAM_ADDR_WIDTH + 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]      len,
    output logic                      busy,
    output logic                      done,
    output logic                      ren,
    output logic [RAM_ADDR_WIDTH-1:0] raddr,
    input  shortreal                  rdat,
    output logic                      w_valid,
    input  logic                      w_ready,
    output shortreal                  w_data,
    output logic                      w_last
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t              r_state, w_nxt_state;
    logic [RAM_ADDR_WIDTH-1:0] r_addr, w_nxt_addr;
    logic [LEN_WIDTH-1:0]      r_issue_rem, w_nxt_issue_rem;
    logic [LEN_WIDTH-1:0]      r_out_rem, w_nxt_out_rem;
    logic [1:0]                r_infl, w_nxt_infl;
    logic                      r_ren, w_nxt_ren;
    logic [RAM_ADDR_WIDTH-1:0] r_raddr, w_nxt_raddr;
    logic                      r_busy, w_nxt_busy;
    logic                      r_done, w_nxt_done;
    logic [BRAM_RD_LAT-1:0]    r_rd_pipe;

    logic [RAM_ADDR_WIDTH-1:0] w_iss_addr;
    logic [LEN_WIDTH-1:0]      w_iss_rem;
    logic                      w_can_issue;
    logic                      w_rvalid;
    logic                      w_push;
    logic                      w_xfer;
    logic [c_CNT_W-1:0]        w_count;
    logic                      w_empty;
    logic                      w_full;
    shortreal                  w_head;

    wght_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (rdat),
        .pop       (w_xfer),
        .pop_data  (w_head),
        .count     (w_count),
        .empty     (w_empty),
        .full      (w_full)
    );

    // A read issued last cycle is returning on rdat this cycle.
    assign w_rvalid = r_rd_pipe[BRAM_RD_LAT-1];
    assign w_push   = w_rvalid && (!w_full || w_xfer);
    assign w_xfer   = !w_empty && w_ready;

    assign busy    = r_busy;
    assign done    = r_done;
    assign ren     = r_ren;
    assign raddr   = r_raddr;
    assign w_valid = !w_empty;
    assign w_data  = w_head;
    assign w_last  = !w_empty && (r_out_rem == LEN_WIDTH'(1));

    // Next-state, credit and issue logic. r_infl counts the read on the bus
    // now plus the one returning now, so the decision for next cycle's read
    // sees every entry that can still land in the FIFO; pops are not credited.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_addr      = r_addr;
        w_nxt_issue_rem = r_issue_rem;
        w_nxt_out_rem   = r_out_rem;
        w_nxt_ren       = 1'b0;
        w_nxt_raddr     = r_raddr;
        w_nxt_busy      = r_busy;
        w_nxt_done      = 1'b0;
        w_iss_addr      = r_addr;
        w_iss_rem       = r_issue_rem;
        w_can_issue     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_done) begin
                    w_nxt_busy = 1'b0;
                end else if (start) begin
                    w_nxt_busy      = 1'b1;
                    w_nxt_addr      = base_addr;
                    w_nxt_issue_rem = len;
                    w_nxt_out_rem   = len;
                    w_iss_addr      = base_addr;
                    w_iss_rem       = len;
                    w_can_issue     = (len != '0);
                    w_nxt_state     = (len == '0) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_can_issue = (r_issue_rem != '0) &&
                              ((int'(w_count) + int'(r_infl)) < FIFO_DEPTH);
            end
            ST_DRAIN: begin
                if ((w_xfer && (r_out_rem == LEN_WIDTH'(1))) || (r_out_rem == '0)) begin
                    w_nxt_done  = 1'b1;
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase

        if (w_xfer) w_nxt_out_rem = r_out_rem - LEN_WIDTH'(1);

        if (w_can_issue) begin
            w_nxt_ren       = 1'b1;
            w_nxt_raddr     = w_iss_addr;
            w_nxt_addr      = RAM_ADDR_WIDTH'(addr_wrap(32'(w_iss_addr) + 32'd1, RAM_DEPTH));
            w_nxt_issue_rem = w_iss_rem - LEN_WIDTH'(1);
            if (w_iss_rem == LEN_WIDTH'(1)) w_nxt_state = ST_DRAIN;
        end

        w_nxt_infl = r_infl + 2'(w_nxt_ren) - 2'(w_rvalid);
    end

    // State register; reset also discards any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_issue_rem <= '0;
            r_out_rem   <= '0;
            r_infl      <= '0;
            r_ren       <= 1'b0;
            r_raddr     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_pipe   <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_addr      <= w_nxt_addr;
            r_issue_rem <= w_nxt_issue_rem;
            r_out_rem   <= w_nxt_out_rem;
            r_infl      <= w_nxt_infl;
            r_ren       <= w_nxt_ren;
            r_raddr     <= w_nxt_raddr;
            r_busy      <= w_nxt_busy;
            r_done      <= w_nxt_done;
            r_rd_pipe   <= BRAM_RD_LAT'({r_rd_pipe, r_ren});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wght_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wght_fetch_ctrl
//  Description : Directed self-checking bench for wght_fetch_ctrl with a
//                1-cycle BRAM model and an independent FIFO occupancy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wght_fetch_ctrl;

    localparam int c_RAM_DEPTH  = 32;
    localparam int c_AW         = 5;
    localparam int c_LW         = 6;
    localparam int c_FIFO_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [c_AW-1:0] base_addr;
    logic [c_LW-1:0] len;
    logic            busy, done, ren;
    logic [c_AW-1:0] raddr;
    shortreal        rdat;
    logic            w_valid;
    logic            w_ready;
    shortreal        w_data;
    logic            w_last;

    wght_fetch_ctrl #(
        .RAM_DEPTH      (c_RAM_DEPTH),
        .RAM_ADDR_WIDTH (c_AW),
        .LEN_WIDTH      (c_LW),
        .FIFO_DEPTH     (c_FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ren       (ren),
        .raddr     (raddr),
        .rdat      (rdat),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    // BRAM model: registered read, w[i] = i + 0.5.
    shortreal bram [c_RAM_DEPTH];
    always @(posedge clk) begin
        if (ren) rdat <= bram[raddr];
    end

    // Occupancy model from port activity: a read seen at edge k lands at k+1.
    int occ = 0;
    int pend = 0;
    int max_occ = 0;
    always @(posedge clk) begin
        if (rst) begin
            occ  = 0;
            pend = 0;
        end else begin
            occ  = occ + pend - ((w_valid && w_ready) ? 1 : 0);
            pend = ren ? 1 : 0;
        end
        if (occ > max_occ) max_occ = occ;
        assert (occ <= c_FIFO_DEPTH)
            else $error("FAIL fifo_overflow: occupancy %0d above %0d", occ, c_FIFO_DEPTH);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input real obs, input real exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0f expected %0f", tag, obs, exp);
    endtask

    // Per-burst observations.
    int       q_ren_cyc[$];
    int       q_raddr[$];
    shortreal q_data[$];
    int       q_xfer_cyc[$];
    int       n_last, last_cyc, n_done, done_cyc, busy_low, busy1;
    int       stall_bad, last_bad;
    shortreal last_val;

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 1) return !(c >= 3 && c <= 10);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    // Drive start in cycle 0, then record activity per cycle (cycle c >= 1).
    task automatic run_burst(input int base, input int n, input int rmode,
                             input int spur_hi, input int budget);
        logic     prev_stall;
        shortreal prev_data;
        prev_stall = 1'b0;
        prev_data  = 0.0;
        q_ren_cyc.delete(); q_raddr.delete(); q_data.delete(); q_xfer_cyc.delete();
        n_last = 0; last_cyc = -1; n_done = 0; done_cyc = -1; busy_low = -1;
        busy1 = 0; stall_bad = 0; last_bad = 0; last_val = -1.0;
        assert (n <= c_RAM_DEPTH) else $error("FAIL len_range: len %0d", n);
        start     = 1'b1;
        base_addr = c_AW'(base);
        len       = c_LW'(n);
        w_ready   = ready_for(rmode, 0);
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            start     = (c <= spur_hi);
            base_addr = c_AW'(base + 9);
            len       = c_LW'(3);
            w_ready   = ready_for(rmode, c);
            @(negedge clk);
            if (c == 1) busy1 = int'(busy);
            if (ren) begin
                q_ren_cyc.push_back(c);
                q_raddr.push_back(int'(raddr));
            end
            if (w_valid && w_ready) begin
                q_data.push_back(w_data);
                q_xfer_cyc.push_back(c);
                if (w_last) begin
                    n_last++;
                    last_cyc = c;
                    last_val = w_data;
                end
            end
            if (w_last && !w_valid) last_bad++;
            if (w_valid && !w_ready) begin
                if (prev_stall && (w_data != prev_data)) stall_bad++;
                prev_stall = 1'b1;
                prev_data  = w_data;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                n_done++;
                done_cyc = c;
            end
            if (n_done > 0 && !busy && busy_low < 0) busy_low = c;
            if (n_done > 0 && c >= done_cyc + 4) break;
        end
        start = 1'b0;
    endtask

    task automatic verify(input string nm, input int base, input int n, input bit full_tp);
        int exp_done;
        chk({nm, "_nxfer"}, q_data.size(), n);
        chk({nm, "_nren"}, q_ren_cyc.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < q_data.size())
                chk($sformatf("%s_data%0d", nm, i), q_data[i], ((base + i) % c_RAM_DEPTH) + 0.5);
            if (i < q_raddr.size())
                chk($sformatf("%s_raddr%0d", nm, i), q_raddr[i], (base + i) % c_RAM_DEPTH);
        end
        chk({nm, "_nlast"}, n_last, (n > 0) ? 1 : 0);
        if (n > 0) chk({nm, "_lastval"}, last_val, ((base + n - 1) % c_RAM_DEPTH) + 0.5);
        chk({nm, "_ndone"}, n_done, 1);
        chk({nm, "_stall_stable"}, stall_bad, 0);
        chk({nm, "_last_wo_valid"}, last_bad, 0);
        if (full_tp) begin
            exp_done = (n == 0) ? 2 : n + 3;
            chk({nm, "_busy_c1"}, busy1, 1);
            for (int i = 0; i < q_ren_cyc.size(); i++)
                chk($sformatf("%s_rencyc%0d", nm, i), q_ren_cyc[i], 1 + i);
            for (int i = 0; i < q_xfer_cyc.size(); i++)
                chk($sformatf("%s_xfercyc%0d", nm, i), q_xfer_cyc[i], 3 + i);
            if (n > 0) chk({nm, "_lastcyc"}, last_cyc, n + 2);
            chk({nm, "_donecyc"}, done_cyc, exp_done);
            chk({nm, "_busylow"}, busy_low, exp_done + 1);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_ren"}, ren, 0);
        chk({nm, "_raddr"}, raddr, 0);
        chk({nm, "_wvalid"}, w_valid, 0);
        chk({nm, "_wdata"}, w_data, 0.0);
        chk({nm, "_wlast"}, w_last, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ren_early, late_act;
        for (int i = 0; i < c_RAM_DEPTH; i++) bram[i] = i + 0.5;
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; w_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst0");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);

        run_burst(0, 4, 0, 0, 40);
        verify("basic", 0, 4, 1'b1);

        run_burst(30, 4, 0, 7, 40);
        verify("wrap", 30, 4, 1'b1);

        max_occ = 0;
        run_burst(0, 8, 1, 0, 80);
        verify("bp", 0, 8, 1'b0);
        ren_early = 0;
        foreach (q_ren_cyc[i]) if (q_ren_cyc[i] <= 10) ren_early++;
        chk("bp_ren_before_release", ren_early, 4);
        chk("bp_max_occ", max_occ, c_FIFO_DEPTH);

        run_burst(7, 32, 2, 0, 400);
        verify("rand", 7, 32, 1'b0);

        run_burst(0, 0, 0, 2, 40);
        verify("len0", 0, 0, 1'b1);

        // Reset in cycle 4 of a len=16 burst.
        start = 1'b1; base_addr = '0; len = c_LW'(16); w_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 4) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        late_act = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (w_valid || done || ren) late_act++;
        end
        chk("midrst_quiet", late_act, 0);

        run_burst(5, 2, 0, 0, 40);
        verify("postrst", 5, 2, 1'b1);

        chk("no_overflow", (max_occ <= c_FIFO_DEPTH) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
